// File: rtl/alu_phase_sequencer_pkg.sv
// Shared constants for the group-3 ALU phase sequencer: state encodings,
// decoder register-sequencing codes, the ALU group code and the default fetch timeout.
package alu_phase_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_COMMIT  = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  localparam logic [2:0] REG_SEQX_NONE    = 3'd0;
  localparam logic [2:0] REG_SEQX_LDA_RDB = 3'd1;
  localparam logic [2:0] REG_SEQX_LDA_IMM = 3'd2;

  localparam logic [1:0] GRP_ALU = 2'b11;

  localparam int FETCH_TIMEOUT_DEF = 15;

  function automatic logic is_alu_grp(input logic [15:0] ir);
    return ir[15:14] == GRP_ALU;
  endfunction

endpackage

// File: rtl/alu_phase_sequencer_if.sv
// Handshake/bus bundle between the phase sequencer (slave) and the memory,
// decoder and ALU side that drives it (master).
interface alu_phase_sequencer_if;
  logic        START;
  logic [15:0] MEM_DATA;
  logic        MEM_ACK;
  logic [2:0]  REG_SEQX;
  logic        CCL_LD_X;
  logic        ALU_BUSY;
  logic        CLEAR_FAULT;

  logic        MEM_REQ;
  logic [15:0] IR;
  logic        FETCH;
  logic        DECODE;
  logic        EXECUTE;
  logic        COMMIT;
  logic        REGA_WE;
  logic        CCL_LATCH;
  logic        BUSY;
  logic        DONE;
  logic        ILLEGAL;
  logic        FAULT;

  modport master (
    output START, MEM_DATA, MEM_ACK, REG_SEQX, CCL_LD_X, ALU_BUSY, CLEAR_FAULT,
    input  MEM_REQ, IR, FETCH, DECODE, EXECUTE, COMMIT, REGA_WE, CCL_LATCH,
           BUSY, DONE, ILLEGAL, FAULT
  );

  modport slave (
    input  START, MEM_DATA, MEM_ACK, REG_SEQX, CCL_LD_X, ALU_BUSY, CLEAR_FAULT,
    output MEM_REQ, IR, FETCH, DECODE, EXECUTE, COMMIT, REGA_WE, CCL_LATCH,
           BUSY, DONE, ILLEGAL, FAULT
  );
endinterface

// File: rtl/alu_phase_sequencer_fetch_timeout_counter.sv
// Counts FETCH cycles without MEM_ACK; tc flags the cycle that would make
// the count reach LIMIT, so the FSM can leave FETCH on that same edge.
module fetch_timeout_counter #(
  parameter int LIMIT = 15,
  parameter int W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign tc = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/alu_phase_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/COMMIT controller for group-3 ALU instructions.
// Define ALU_STALL_EN to hold EXECUTE while ALU_BUSY is high; otherwise ALU_BUSY is ignored.
module alu_phase_sequencer
  import alu_phase_sequencer_pkg::*;
#(
  parameter int FETCH_TIMEOUT = FETCH_TIMEOUT_DEF,
  parameter int TO_W          = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  alu_phase_sequencer_if.slave  bus
);

  state_t      state;
  logic [15:0] ir;
  logic        rega_we, ccl_latch, done, illegal;
  logic        to_en, to_clr, to_tc;
  logic        exec_ok;

`ifdef ALU_STALL_EN
  assign exec_ok = !bus.ALU_BUSY;
`else
  logic alu_busy_unused;
  assign alu_busy_unused = bus.ALU_BUSY;
  assign exec_ok = 1'b1;
`endif

  // Counter only runs while FETCH waits; any exit from FETCH rearms it.
  assign to_en  = (state == ST_FETCH) && !bus.MEM_ACK;
  assign to_clr = (state != ST_FETCH) || bus.MEM_ACK || to_tc;

  fetch_timeout_counter #(
    .LIMIT (FETCH_TIMEOUT),
    .W     (TO_W)
  ) u_to (
    .clk (CLK),
    .rst (RESET),
    .en  (to_en),
    .clr (to_clr),
    .tc  (to_tc)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      ir        <= '0;
      rega_we   <= 1'b0;
      ccl_latch <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      rega_we   <= 1'b0;
      ccl_latch <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        ST_IDLE:    if (bus.START) state <= ST_FETCH;
        ST_FETCH: begin
          if (bus.MEM_ACK) begin
            ir    <= bus.MEM_DATA;
            state <= ST_DECODE;
          end else if (to_tc) begin
            state <= ST_FAULT;
          end
        end
        ST_DECODE:  state <= ST_EXECUTE;
        ST_EXECUTE: begin
          // Commit strobes are registered on entry so they are clean for the COMMIT cycle.
          if (exec_ok) begin
            state     <= ST_COMMIT;
            done      <= 1'b1;
            rega_we   <= is_alu_grp(ir) && (bus.REG_SEQX != REG_SEQX_NONE);
            ccl_latch <= is_alu_grp(ir) && bus.CCL_LD_X;
            illegal   <= !is_alu_grp(ir);
          end
        end
        ST_COMMIT:  state <= bus.START ? ST_FETCH : ST_IDLE;
        ST_FAULT:   if (bus.CLEAR_FAULT) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign bus.MEM_REQ   = (state == ST_FETCH);
  assign bus.FETCH     = (state == ST_FETCH);
  assign bus.DECODE    = (state == ST_DECODE);
  assign bus.EXECUTE   = (state == ST_EXECUTE);
  assign bus.COMMIT    = (state == ST_COMMIT);
  assign bus.BUSY      = (state != ST_IDLE) && (state != ST_FAULT);
  assign bus.FAULT     = (state == ST_FAULT);
  assign bus.IR        = ir;
  assign bus.REGA_WE   = rega_we;
  assign bus.CCL_LATCH = ccl_latch;
  assign bus.DONE      = done;
  assign bus.ILLEGAL   = illegal;

endmodule

// File: tb/tb_alu_phase_sequencer.sv
// Randomized self-checking bench for alu_phase_sequencer against a per-instruction phase model.
module tb_alu_phase_sequencer;

  localparam int TO = 15;
  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_COMMIT = 4, P_FAULT = 5;

  logic clk, rst;
  int   n_tests, n_fail;
  logic [15:0] ir_model;

  alu_phase_sequencer_if bus();

  alu_phase_sequencer #(.FETCH_TIMEOUT(TO), .TO_W(8)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {MEM_REQ,FETCH,DECODE,EXECUTE,COMMIT,REGA_WE,CCL_LATCH,BUSY,DONE,ILLEGAL,FAULT}
  logic [10:0] obs;
  assign obs = {bus.MEM_REQ, bus.FETCH, bus.DECODE, bus.EXECUTE, bus.COMMIT,
                bus.REGA_WE, bus.CCL_LATCH, bus.BUSY, bus.DONE, bus.ILLEGAL, bus.FAULT};

  function automatic logic [10:0] exp_out(input int p, input bit we, input bit cl, input bit il);
    logic [10:0] v;
    v = '0;
    if (p == P_FETCH)  v = 11'b11000_00_1_0_0_0;
    if (p == P_DECODE) v = 11'b00100_00_1_0_0_0;
    if (p == P_EXEC)   v = 11'b00010_00_1_0_0_0;
    if (p == P_COMMIT) v = {5'b00001, we, cl, 1'b1, 1'b1, il, 1'b0};
    if (p == P_FAULT)  v = 11'b00000_00_0_0_0_1;
    return v;
  endfunction

  task automatic run_instr(input logic [15:0] data, input logic [2:0] seqx, input logic ccl,
                           input int ack_dly, input int stall, input string tag);
    bit alu, we, cl;
    int exec_n;
    alu = (data[15:14] == 2'b11);
    we  = alu && (seqx != 3'd0);
    cl  = alu && ccl;
    bus.REG_SEQX = seqx; bus.CCL_LD_X = ccl; bus.MEM_ACK = 1'b0; bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    for (int c = 0; c < TO; c++) begin
      n_tests++;
      if (obs !== exp_out(P_FETCH, 0, 0, 0)) begin
        n_fail++; $display("FAIL %s fetch%0d: got %b want %b", tag, c, obs, exp_out(P_FETCH, 0, 0, 0));
      end
      bus.MEM_ACK  = (c == ack_dly);
      bus.MEM_DATA = (c == ack_dly) ? data : 16'($urandom);
      @(negedge clk);
      if (c == ack_dly) break;
    end
    bus.MEM_ACK = 1'b0;
    if (ack_dly >= TO) begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if ({obs, bus.IR} !== {exp_out(P_FAULT, 0, 0, 0), ir_model}) begin
          n_fail++; $display("FAIL %s fault%0d: got %b/%h want %b/%h", tag, k, obs, bus.IR,
                             exp_out(P_FAULT, 0, 0, 0), ir_model);
        end
        bus.START = 1'b1;
        @(negedge clk);
      end
      bus.START = 1'b0; bus.CLEAR_FAULT = 1'b1;
      @(negedge clk);
      bus.CLEAR_FAULT = 1'b0;
      n_tests++;
      if (obs !== exp_out(P_IDLE, 0, 0, 0)) begin
        n_fail++; $display("FAIL %s clear: got %b want %b", tag, obs, exp_out(P_IDLE, 0, 0, 0));
      end
      return;
    end
    ir_model = data;
    n_tests++;
    if ({obs, bus.IR} !== {exp_out(P_DECODE, 0, 0, 0), data}) begin
      n_fail++; $display("FAIL %s decode: got %b/%h want %b/%h", tag, obs, bus.IR,
                         exp_out(P_DECODE, 0, 0, 0), data);
    end
    @(negedge clk);
    exec_n = 1;
`ifdef ALU_STALL_EN
    exec_n = stall + 1;
`endif
    for (int s = 0; s < exec_n; s++) begin
      n_tests++;
      if (obs !== exp_out(P_EXEC, 0, 0, 0)) begin
        n_fail++; $display("FAIL %s exec%0d: got %b want %b", tag, s, obs, exp_out(P_EXEC, 0, 0, 0));
      end
      bus.ALU_BUSY = (s < stall);
      @(negedge clk);
    end
    bus.ALU_BUSY = 1'b0;
    n_tests++;
    if (obs !== exp_out(P_COMMIT, we, cl, !alu)) begin
      n_fail++; $display("FAIL %s commit: got %b want %b", tag, obs, exp_out(P_COMMIT, we, cl, !alu));
    end
    @(negedge clk);
    n_tests++;
    if (obs !== exp_out(P_IDLE, 0, 0, 0)) begin
      n_fail++; $display("FAIL %s idle: got %b want %b", tag, obs, exp_out(P_IDLE, 0, 0, 0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.START = 0; bus.MEM_DATA = '0; bus.MEM_ACK = 0; bus.REG_SEQX = '0;
    bus.CCL_LD_X = 0; bus.ALU_BUSY = 0; bus.CLEAR_FAULT = 0;
    ir_model = '0;
    #3;
    n_tests++;
    if ({obs, bus.IR} !== 27'd0) begin
      n_fail++; $display("FAIL reset: got %b/%h want 0/0000", obs, bus.IR);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({obs, bus.IR} !== 27'd0) begin
      n_fail++; $display("FAIL reset_idle: got %b/%h want 0/0000", obs, bus.IR);
    end
  endtask

  task automatic test_directed();
    run_instr(16'hC012, 3'd1, 1'b1, 0, 0, "alu_rdb");
    run_instr(16'h4012, 3'd1, 1'b1, 0, 0, "illegal");
    run_instr(16'hC3A5, 3'd0, 1'b0, 2, 0, "alu_nowrite");
    run_instr(16'hC0FF, 3'd2, 1'b1, TO - 1, 0, "ack_last");
    run_instr(16'hC777, 3'd1, 1'b1, 100, 0, "timeout");
    run_instr(16'hC0AA, 3'd1, 1'b0, 0, 3, "stall3");
  endtask

  task automatic test_back_to_back();
    logic [15:0] d [4];
    int p, idx;
    for (int i = 0; i < 4; i++) begin
      d[i] = 16'($urandom);
      d[i][15:14] = 2'b11;
    end
    bus.REG_SEQX = 3'd2; bus.CCL_LD_X = 1'b1; bus.MEM_ACK = 1'b1; bus.START = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      p = (k % 4) + 1; idx = k / 4;
      n_tests++;
      if (obs !== exp_out(p, 1, 1, 0)) begin
        n_fail++; $display("FAIL b2b cyc%0d: got %b want %b", k, obs, exp_out(p, 1, 1, 0));
      end
      if (p == P_FETCH) bus.MEM_DATA = d[idx];
      if (p == P_DECODE) begin
        n_tests++;
        if (bus.IR !== d[idx]) begin
          n_fail++; $display("FAIL b2b ir%0d: got %h want %h", idx, bus.IR, d[idx]);
        end
      end
      if (p == P_COMMIT && idx == 3) bus.START = 1'b0;
    end
    ir_model = d[3];
    bus.MEM_ACK = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs !== exp_out(P_IDLE, 0, 0, 0)) begin
      n_fail++; $display("FAIL b2b end: got %b want %b", obs, exp_out(P_IDLE, 0, 0, 0));
    end
  endtask

  task automatic test_reset_mid();
    bus.REG_SEQX = 3'd1; bus.CCL_LD_X = 1'b1; bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0; bus.MEM_ACK = 1'b1; bus.MEM_DATA = 16'hC155;
    @(negedge clk);
    bus.MEM_ACK = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obs !== exp_out(P_EXEC, 0, 0, 0)) begin
      n_fail++; $display("FAIL rmid pre: got %b want %b", obs, exp_out(P_EXEC, 0, 0, 0));
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({obs, bus.IR} !== 27'd0) begin
      n_fail++; $display("FAIL rmid async: got %b/%h want 0/0000", obs, bus.IR);
    end
    ir_model = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if ({obs, bus.IR} !== 27'd0) begin
        n_fail++; $display("FAIL rmid after%0d: got %b/%h want 0/0000", k, obs, bus.IR);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] data;
    int ack_dly;
    for (int i = 0; i < 40; i++) begin
      data = 16'($urandom);
      if ($urandom_range(0, 1) == 1) data[15:14] = 2'b11;
      ack_dly = ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 5)) : int'($urandom_range(0, 4));
      run_instr(data, 3'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), ack_dly,
                int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
